// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared types and helpers for the load/store unit: func3 codes, FSM state
// encoding, access size decoding and func3 legality.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} lsu_state_t;

  // Access size in bytes: 1/2/4/8 from the low two func3 bits.
  function automatic int unsigned size_of(input logic [2:0] func3);
    return 32'd1 << func3[1:0];
  endfunction

  function automatic logic func3_legal(input logic [2:0] func3, input logic we,
                                       input int xlen);
    if (func3 == 3'b111) return 1'b0;
    if (we && func3[2]) return 1'b0;
    if (xlen == 32 && (func3 == F3_D || func3 == F3_WU)) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Core-side request/response channel and word-wide memory bus channel of the
// load/store unit.
interface lsu_req_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_func3;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [XLEN-1:0]   rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_func3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input  req_valid, req_we, req_func3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

interface lsu_bus_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [XLEN/8-1:0] bus_be;
  logic [XLEN-1:0]   bus_wdata;
  logic              bus_ack;
  logic [XLEN-1:0]   bus_rdata;
  logic              bus_err;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata, bus_err
  );
  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata, bus_err
  );
endinterface

// File: rtl/lsu_mem_ctrl_align.sv
// Combinational lane alignment: positions store data and byte enables across
// two words, and extracts/extends load data from a two-word window.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]                    func3_i,
  input  logic [$clog2(XLEN/8)-1:0]     off_i,
  input  logic [XLEN-1:0]               wdata_i,
  input  logic [XLEN-1:0]               lo_i,
  input  logic [XLEN-1:0]               hi_i,
  output logic [2*XLEN-1:0]             wide_o,
  output logic [2*(XLEN/8)-1:0]         be2_o,
  output logic                          need_b1_o,
  output logic [XLEN-1:0]               load_o
);

  localparam int NB   = XLEN / 8;
  localparam int SH_W = $clog2(XLEN) + 1;

  int                      nbits;
  logic [SH_W-1:0]         pad;
  logic [2*NB-1:0]         mask;
  logic [2*XLEN-1:0]       rd_sh;
  logic [XLEN-1:0]         rd_left;
  logic signed [XLEN-1:0]  ld_s;

  always_comb begin
    // NOTE: every variable is assigned unconditionally first so no path can
    // leave a previous value held, which would infer a latch.
    nbits = 8 * int'(size_of(func3_i));
    if (nbits > XLEN) nbits = XLEN;
    pad     = SH_W'(XLEN - nbits);
    mask    = ~({(2*NB){1'b1}} << size_of(func3_i));
    be2_o   = mask << off_i;
    wide_o  = {{XLEN{1'b0}}, wdata_i} << {off_i, 3'b000};
    rd_sh   = {hi_i, lo_i} >> {off_i, 3'b000};
    // Push the wanted bytes to the top, then shift back to extend.
    rd_left = rd_sh[XLEN-1:0] << pad;
    ld_s    = $signed(rd_left) >>> pad;
    load_o  = func3_i[2] ? (rd_left >> pad) : ld_s;
  end

  assign need_b1_o = |be2_o[2*NB-1:NB];

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Sequential load/store unit: one outstanding request, misaligned accesses
// split into two bus beats, per-beat wait-state timeout, registered outputs.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int ADDR_W         = 32,
  parameter int MISALIGN_SPLIT = 1,
  parameter int TIMEOUT        = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  lsu_req_if.slave   core_if,
  lsu_bus_if.master  mem_if
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int TO_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  lsu_state_t        state_q;
  logic              req_ready_q, rsp_valid_q, rsp_err_q;
  logic [XLEN-1:0]   rsp_rdata_q;
  logic              bus_req_q, bus_we_q;
  logic [ADDR_W-1:0] bus_addr_q, addr1_q;
  logic [NB-1:0]     bus_be_q, be1_q;
  logic [XLEN-1:0]   bus_wdata_q, wdata1_q, rdata0_q;
  logic              we_q, need_b1_q;
  logic [2:0]        func3_q;
  logic [OFF_W-1:0]  off_q;
  logic [TO_W-1:0]   cnt_q;

  logic [2:0]        a_func3;
  logic [OFF_W-1:0]  a_off, in_off;
  logic [XLEN-1:0]   a_lo, a_hi, ld_data;
  logic [2*XLEN-1:0] wide;
  logic [2*NB-1:0]   be2;
  logic              need_b1, accept, misal, early_err, to_hit, beat_done, beat_fail;
  logic [ADDR_W-1:0] word_addr;

  // The aligner sees the incoming request while idle and the held one afterwards.
  assign in_off  = core_if.req_addr[OFF_W-1:0];
  assign a_func3 = (state_q == IDLE) ? core_if.req_func3 : func3_q;
  assign a_off   = (state_q == IDLE) ? in_off : off_q;
  assign a_lo    = (state_q == BEAT1) ? rdata0_q : mem_if.bus_rdata;
  assign a_hi    = (state_q == BEAT1) ? mem_if.bus_rdata : '0;

  lsu_align #(.XLEN(XLEN)) u_align (
    .func3_i   (a_func3),
    .off_i     (a_off),
    .wdata_i   (core_if.req_wdata),
    .lo_i      (a_lo),
    .hi_i      (a_hi),
    .wide_o    (wide),
    .be2_o     (be2),
    .need_b1_o (need_b1),
    .load_o    (ld_data)
  );

  assign accept    = core_if.req_valid && req_ready_q;
  assign misal     = |(in_off & OFF_W'(size_of(core_if.req_func3) - 1));
  assign early_err = !func3_legal(core_if.req_func3, core_if.req_we, XLEN) ||
                     (misal && MISALIGN_SPLIT == 0);
  assign word_addr = {core_if.req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
  assign to_hit    = (TIMEOUT != 0) && (cnt_q == TO_W'(TIMEOUT - 1));
  assign beat_done = mem_if.bus_ack || to_hit;
  assign beat_fail = mem_if.bus_ack ? mem_if.bus_err : 1'b1;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      addr1_q     <= '0;
      be1_q       <= '0;
      wdata1_q    <= '0;
      rdata0_q    <= '0;
      we_q        <= 1'b0;
      need_b1_q   <= 1'b0;
      func3_q     <= '0;
      off_q       <= '0;
      cnt_q       <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (accept) begin
          req_ready_q <= 1'b0;
          we_q        <= core_if.req_we;
          func3_q     <= core_if.req_func3;
          off_q       <= in_off;
          cnt_q       <= '0;
          if (early_err) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
          end else begin
            state_q     <= BEAT0;
            bus_req_q   <= 1'b1;
            bus_we_q    <= core_if.req_we;
            bus_addr_q  <= word_addr;
            bus_be_q    <= be2[NB-1:0];
            bus_wdata_q <= core_if.req_we ? wide[XLEN-1:0] : '0;
            addr1_q     <= word_addr + ADDR_W'(NB);
            be1_q       <= be2[2*NB-1:NB];
            wdata1_q    <= core_if.req_we ? wide[2*XLEN-1:XLEN] : '0;
            need_b1_q   <= need_b1;
          end
        end
        BEAT0, BEAT1: if (beat_done) begin
          cnt_q <= '0;
          if (state_q == BEAT0 && need_b1_q && !beat_fail) begin
            state_q     <= BEAT1;
            bus_addr_q  <= addr1_q;
            bus_be_q    <= be1_q;
            bus_wdata_q <= wdata1_q;
            rdata0_q    <= mem_if.bus_rdata;
          end else begin
            state_q     <= RESP;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= beat_fail;
            rsp_rdata_q <= (beat_fail || we_q) ? '0 : ld_data;
          end
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        RESP: if (core_if.rsp_ready) begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign core_if.req_ready = req_ready_q;
  assign core_if.rsp_valid = rsp_valid_q;
  assign core_if.rsp_rdata = rsp_rdata_q;
  assign core_if.rsp_err   = rsp_err_q;
  assign mem_if.bus_req    = bus_req_q;
  assign mem_if.bus_we     = bus_we_q;
  assign mem_if.bus_addr   = bus_addr_q;
  assign mem_if.bus_be     = bus_be_q;
  assign mem_if.bus_wdata  = bus_wdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Testbench for lsu_mem_ctrl (XLEN=32, split on, TIMEOUT=4): directed vector
// table, hand-written corner sequences and random traffic vs a byte-level model.
module tb_lsu_mem_ctrl;

  logic clk, rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  lsu_req_if #(.XLEN(32), .ADDR_W(32)) lif ();
  lsu_bus_if #(.XLEN(32), .ADDR_W(32)) bif ();

  lsu_mem_ctrl #(.XLEN(32), .ADDR_W(32), .MISALIGN_SPLIT(1), .TIMEOUT(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .core_if (lif),
    .mem_if  (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } beat_t;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          beats;
  } vec_t;

  // Bus-side word memory, model-side byte memory; both default to dflt_word.
  logic [31:0] bus_mem [logic [31:0]];
  logic [7:0]  ref_mem [logic [31:0]];
  beat_t       beat_log [$];
  int          req_cycles = 0;
  int          max_wait   = 0;
  bit          no_ack     = 0;
  bit          err_next   = 0;

  function automatic logic [31:0] dflt_word(input logic [31:0] w);
    return (w * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] rd_word(input logic [31:0] w);
    return bus_mem.exists(w) ? bus_mem[w] : dflt_word(w);
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    logic [31:0] w;
    if (ref_mem.exists(a)) return ref_mem[a];
    w = dflt_word({a[31:2], 2'b00});
    return w[8*a[1:0] +: 8];
  endfunction

  task automatic poke(input logic [31:0] w, input logic [31:0] v);
    bus_mem[w] = v;
    for (int i = 0; i < 4; i++) ref_mem[w + 32'(i)] = v[8*i +: 8];
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: a request touches s consecutive bytes starting at addr.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic err, output logic [31:0] rd,
                       output int beats);
    int s;
    logic [31:0] v;
    err   = (f3 == 3'b111) || (f3 == 3'b011) || (f3 == 3'b110) || (we && f3[2]);
    rd    = '0;
    beats = 0;
    if (err) return;
    s     = 1 << f3[1:0];
    beats = (int'(a[1:0]) + s > 4) ? 2 : 1;
    if (we) begin
      for (int i = 0; i < s; i++) ref_mem[a + 32'(i)] = wd[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < s; i++) v = v | (32'(ref_byte(a + 32'(i))) << (8*i));
      if (!f3[2] && v[8*s-1]) v = v | (32'hFFFF_FFFF << (8*s));
      rd = v;
    end
  endtask

  // Bus slave with random wait states, error injection and beat logging.
  initial begin : slave
    int          wcnt, target;
    logic [31:0] w;
    wcnt = 0;
    target = 0;
    bif.bus_ack = 1'b0; bif.bus_rdata = '0; bif.bus_err = 1'b0;
    forever begin
      @(posedge clk); #1;
      bif.bus_ack = 1'b0; bif.bus_err = 1'b0; bif.bus_rdata = '0;
      if (bif.bus_req) begin
        req_cycles++;
        if (!no_ack && wcnt >= target) begin
          bif.bus_ack = 1'b1;
          beat_log.push_back('{bif.bus_we, bif.bus_addr, bif.bus_be, bif.bus_wdata});
          if (err_next) begin
            bif.bus_err = 1'b1;
            err_next = 0;
          end else if (bif.bus_we) begin
            w = rd_word(bif.bus_addr);
            for (int b = 0; b < 4; b++)
              if (bif.bus_be[b]) w[8*b +: 8] = bif.bus_wdata[8*b +: 8];
            bus_mem[bif.bus_addr] = w;
          end else begin
            bif.bus_rdata = rd_word(bif.bus_addr);
          end
          wcnt = 0;
          target = $urandom_range(0, max_wait);
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
        target = $urandom_range(0, max_wait);
      end
    end
  end

  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic exp_err, input logic [31:0] exp_rd,
                        input int exp_lat, input int exp_beats, input int hold,
                        output int req_cyc);
    int n, lat, b0, c0;
    req_cyc = 0;
    lif.req_we = we; lif.req_func3 = f3; lif.req_addr = a; lif.req_wdata = wd;
    lif.req_valid = 1'b1;
    n = 0;
    while (!lif.req_ready && n < 20) begin @(posedge clk); #1; n++; end
    check({tag, "_accept"}, lif.req_ready, 1);
    if (!lif.req_ready) begin lif.req_valid = 1'b0; return; end
    b0 = beat_log.size();
    c0 = req_cycles;
    @(posedge clk); #1;
    lif.req_valid = 1'b0;
    lat = 1;
    while (!lif.rsp_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    check({tag, "_rsp_valid"}, lif.rsp_valid, 1);
    if (!lif.rsp_valid) return;
    req_cyc = req_cycles - c0;
    check({tag, "_err"}, lif.rsp_err, exp_err);
    check({tag, "_rdata"}, lif.rsp_rdata, exp_rd);
    if (exp_lat >= 0) check({tag, "_latency"}, lat, exp_lat);
    if (exp_beats >= 0) check({tag, "_beats"}, beat_log.size() - b0, exp_beats);
    for (int k = 0; k < hold; k++) begin
      check({tag, "_hold_valid"}, lif.rsp_valid, 1);
      check({tag, "_hold_ready"}, lif.req_ready, 0);
      check({tag, "_hold_rdata"}, lif.rsp_rdata, exp_rd);
      check({tag, "_hold_err"}, lif.rsp_err, exp_err);
      @(posedge clk); #1;
    end
    lif.rsp_ready = 1'b1;
    @(posedge clk); #1;
    lif.rsp_ready = 1'b0;
    check({tag, "_idle_again"}, lif.req_ready, 1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t        vecs [12];
    int          rc, nb, hold;
    logic        e_err, we;
    logic [2:0]  f3;
    logic [31:0] e_rd, a, wd;

    vecs[0]  = '{1'b0, 3'b010, 32'h0000_0100, 32'h0, 1'b0, 32'h8000_00F0, 2, 1};
    vecs[1]  = '{1'b0, 3'b000, 32'h0000_0103, 32'h0, 1'b0, 32'hFFFF_FF80, 2, 1};
    vecs[2]  = '{1'b0, 3'b100, 32'h0000_0103, 32'h0, 1'b0, 32'h0000_0080, 2, 1};
    vecs[3]  = '{1'b0, 3'b001, 32'h0000_0102, 32'h0, 1'b0, 32'hFFFF_8000, 2, 1};
    vecs[4]  = '{1'b0, 3'b101, 32'h0000_0102, 32'h0, 1'b0, 32'h0000_8000, 2, 1};
    vecs[5]  = '{1'b0, 3'b000, 32'h0000_0100, 32'h0, 1'b0, 32'hFFFF_FFF0, 2, 1};
    vecs[6]  = '{1'b0, 3'b001, 32'hFFFF_FFFF, 32'h0, 1'b0, 32'h0000_2211, 3, 2};
    vecs[7]  = '{1'b0, 3'b011, 32'h0000_0100, 32'h0, 1'b1, 32'h0, 1, 0};
    vecs[8]  = '{1'b0, 3'b110, 32'h0000_0100, 32'h0, 1'b1, 32'h0, 1, 0};
    vecs[9]  = '{1'b0, 3'b111, 32'h0000_0100, 32'h0, 1'b1, 32'h0, 1, 0};
    vecs[10] = '{1'b1, 3'b100, 32'h0000_0100, 32'h5, 1'b1, 32'h0, 1, 0};
    vecs[11] = '{1'b1, 3'b010, 32'h0000_0104, 32'h1234_5678, 1'b0, 32'h0, 2, 1};

    poke(32'h0000_0100, 32'h8000_00F0);
    poke(32'hFFFF_FFFC, 32'h1122_3344);
    poke(32'h0000_0000, 32'h5566_7722);

    lif.req_valid = 1'b0; lif.req_we = 1'b0; lif.req_func3 = '0;
    lif.req_addr = '0; lif.req_wdata = '0; lif.rsp_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_req_ready", lif.req_ready, 1);
    check("reset_rsp_valid", lif.rsp_valid, 0);
    check("reset_rsp_err", lif.rsp_err, 0);
    check("reset_rsp_rdata", lif.rsp_rdata, 0);
    check("reset_bus_req", bif.bus_req, 0);

    for (int i = 0; i < 12; i++) begin
      do_req($sformatf("vec%0d", i), vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
             vecs[i].err, vecs[i].rdata, vecs[i].lat, vecs[i].beats, 0, rc);
      if (vecs[i].beats == 0) check($sformatf("vec%0d_no_bus_req", i), rc, 0);
    end

    // Backpressure: response held five cycles with rsp_ready low.
    do_req("backpressure", 1'b0, 3'b010, 32'h100, 32'h0, 1'b0, 32'h8000_00F0, 2, 1, 5, rc);

    // Misaligned store split into two beats.
    nb = beat_log.size();
    do_req("sw_split", 1'b1, 3'b010, 32'h101, 32'hAABB_CCDD, 1'b0, 32'h0, 3, 2, 0, rc);
    if (beat_log.size() >= nb + 2) begin
      check("sw_b0_addr", beat_log[nb].addr, 32'h100);
      check("sw_b0_be", beat_log[nb].be, 4'b1110);
      check("sw_b0_wdata", beat_log[nb].wdata, 32'hBBCC_DD00);
      check("sw_b0_we", beat_log[nb].we, 1);
      check("sw_b1_addr", beat_log[nb+1].addr, 32'h104);
      check("sw_b1_be", beat_log[nb+1].be, 4'b0001);
      check("sw_b1_wdata", beat_log[nb+1].wdata, 32'h0000_00AA);
    end
    do_req("sw_readback", 1'b0, 3'b010, 32'h101, 32'h0, 1'b0, 32'hAABB_CCDD, 3, 2, 0, rc);

    // Timeout: no ack at all.
    no_ack = 1;
    do_req("timeout", 1'b0, 3'b010, 32'h200, 32'h0, 1'b1, 32'h0, -1, 0, 0, rc);
    check("timeout_req_cycles", rc, 4);
    no_ack = 0;

    // Bus error on beat0 of a split load suppresses beat1.
    err_next = 1;
    do_req("buserr_split", 1'b0, 3'b010, 32'h102, 32'h0, 1'b1, 32'h0, 2, 1, 0, rc);

    // Asynchronous reset while a beat is waiting.
    no_ack = 1;
    lif.req_we = 1'b0; lif.req_func3 = 3'b010; lif.req_addr = 32'h300;
    lif.req_valid = 1'b1;
    @(posedge clk); #1;
    lif.req_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_busreq_before", bif.bus_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_busreq_async", bif.bus_req, 0);
    check("rst_mid_rsp_valid", lif.rsp_valid, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    no_ack = 0;
    @(posedge clk); #1;
    check("rst_mid_req_ready", lif.req_ready, 1);
    check("rst_mid_no_rsp", lif.rsp_valid, 0);

    // Random traffic against the byte-level model.
    max_wait = 3;
    for (int i = 0; i < 80; i++) begin
      f3 = 3'($urandom_range(0, 7));
      we = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7))
                                       : 32'h1000 + 32'($urandom_range(0, 63));
      wd = $urandom;
      hold = $urandom_range(0, 2);
      model(we, f3, a, wd, e_err, e_rd, nb);
      do_req($sformatf("rnd%0d", i), we, f3, a, wd, e_err, e_rd, -1, nb, hold, rc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
